// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive peripheral.
package uart_rx_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_rx_state_t;

    localparam int   MIN_DIV     = 4;
    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;

    // High when the received parity bit disagrees with the programmed parity sense.
    function automatic logic parity_fault(input logic data_xor, input logic sample,
                                          input logic ptype);
        case (ptype)
            PARITY_EVEN: return data_xor ^ sample;
            PARITY_ODD:  return ~(data_xor ^ sample);
            default:     return data_xor ^ sample;
        endcase
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive FIFO: head data is visible whenever not empty.
// A pop on an empty FIFO is ignored; a push while full is accepted only with a same-cycle pop.
module uart_rx_fifo #(
    parameter int DEPTH = 256,
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_empty,
    output logic             o_full
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);
    assign o_rdata   = o_empty ? '0 : r_mem[r_rptr];

    // Storage write; contents are qualified by r_count so they need no reset.
    // NOTE: memory arrays are left out of reset so they map onto RAM; only the pointers and count are reset.
    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    // Pointer and occupancy tracking; pointers wrap naturally at DEPTH (power of two).
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + AW'(1);
            if (w_do_pop)  r_rptr <= r_rptr + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_peripheral.sv
// UART receive peripheral: synchronizer, oversampling deframer FSM and RX FIFO.
// Build option: define UART_RX_MAJORITY_EN to take each bit as the 2-of-3 majority
// of samples at mid-1, mid and mid+1 (decision at mid+1).
module uart_rx_peripheral
    import uart_rx_pkg::*;
#(
    parameter int FIFO_DEPTH = 256,
    parameter int DATA_WIDTH = 8,
    parameter int DIV_WIDTH  = 20
) (
    input  logic                  i_uart_clk,
    input  logic                  i_uart_rst,
    input  logic [DIV_WIDTH-1:0]  i_uart_baud_divisor,
    input  logic                  i_uart_parity_en,
    input  logic                  i_uart_parity_type,
    input  logic                  i_uart_rx_sdata,
    input  logic                  i_uart_rx_ready,
    output logic [DATA_WIDTH-1:0] o_uart_rx_pdata,
    output logic                  o_uart_rx_valid,
    output logic                  o_uart_fifo_full,
    output logic                  o_uart_rx_busy,
    output logic                  o_uart_parity_err,
    output logic                  o_uart_frame_err,
    output logic                  o_uart_overrun
);

    localparam int BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    uart_rx_state_t         r_state;
    uart_rx_state_t         w_next_state;
    logic                   r_sync1;
    logic                   r_sync2;
    logic                   r_rx_prev;
    logic [DIV_WIDTH-1:0]   r_div;
    logic [DIV_WIDTH-1:0]   r_cnt;
    logic [DIV_WIDTH-1:0]   w_eff_div;
    logic [DIV_WIDTH-1:0]   w_target;
    logic                   r_par_en;
    logic                   r_par_type;
    logic [DATA_WIDTH-1:0]  r_data;
    logic [BCW-1:0]         r_bitcnt;
    logic                   r_perr;
    logic                   r_stop_bit;
    logic                   r_decide;
    logic                   w_rx;
    logic                   w_bit;
    logic                   w_start_edge;
    logic                   w_tick;
    logic                   w_last_bit;
    logic                   w_good;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_empty;
    logic                   w_full;

    // Two-flop synchronizer for the asynchronous line, idle-high after reset.
    // NOTE: clocked state always uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge i_uart_clk) begin
        if (i_uart_rst) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_sync1   <= i_uart_rx_sdata;
            r_sync2   <= r_sync1;
            r_rx_prev <= r_sync2;
        end
    end

    assign w_rx         = r_sync2;
    assign w_start_edge = r_rx_prev & ~w_rx;
    assign w_eff_div    = (i_uart_baud_divisor < DIV_WIDTH'(MIN_DIV)) ?
                          DIV_WIDTH'(MIN_DIV) : i_uart_baud_divisor;

`ifdef UART_RX_MAJORITY_EN
    localparam logic [DIV_WIDTH-1:0] START_OFS = DIV_WIDTH'(1);
    logic [1:0] r_hist;

    // Holds the two previous synced samples (mid-1, mid) for the majority vote at mid+1.
    always_ff @(posedge i_uart_clk) begin
        if (i_uart_rst) r_hist <= 2'b11;
        else            r_hist <= {r_hist[0], w_rx};
    end

    assign w_bit = (r_hist[1] & r_hist[0]) | (r_hist[1] & w_rx) | (r_hist[0] & w_rx);
`else
    localparam logic [DIV_WIDTH-1:0] START_OFS = '0;

    assign w_bit = w_rx;
`endif

    // START waits half a bit to land mid-bit; every later bit is one full period apart.
    assign w_target   = (r_state == START) ? ((r_div >> 1) - DIV_WIDTH'(1) + START_OFS)
                                           : (r_div - DIV_WIDTH'(1));
    assign w_tick     = (r_cnt == w_target);
    assign w_last_bit = (r_bitcnt == BCW'(DATA_WIDTH - 1));

    // State register.
    always_ff @(posedge i_uart_clk) begin
        if (i_uart_rst) r_state <= IDLE;
        else            r_state <= w_next_state;
    end

    // Next-state logic for the deframer.
    // NOTE: default assignment first so no path through the case leaves w_next_state unassigned (no latch).
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_start_edge) w_next_state = START;
            START:   if (w_tick) w_next_state = w_bit ? IDLE : DATA;
            DATA:    if (w_tick && w_last_bit) w_next_state = r_par_en ? PARITY : STOP;
            PARITY:  if (w_tick) w_next_state = STOP;
            STOP:    if (w_tick) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Baud counter, frame configuration capture, shift register and stop-bit verdict.
    always_ff @(posedge i_uart_clk) begin
        if (i_uart_rst) begin
            r_div      <= DIV_WIDTH'(MIN_DIV);
            r_par_en   <= 1'b0;
            r_par_type <= 1'b0;
            r_cnt      <= '0;
            r_bitcnt   <= '0;
            r_data     <= '0;
            r_perr     <= 1'b0;
            r_stop_bit <= 1'b0;
            r_decide   <= 1'b0;
        end else begin
            r_decide <= 1'b0;
            if (r_state == IDLE) begin
                r_cnt    <= '0;
                r_bitcnt <= '0;
                if (w_start_edge) begin
                    r_div      <= w_eff_div;
                    r_par_en   <= i_uart_parity_en;
                    r_par_type <= i_uart_parity_type;
                    r_perr     <= 1'b0;
                end
            end else begin
                r_cnt <= w_tick ? '0 : r_cnt + DIV_WIDTH'(1);
                if (w_tick) begin
                    case (r_state)
                        DATA: begin
                            r_data   <= {w_bit, r_data[DATA_WIDTH-1:1]};
                            r_bitcnt <= r_bitcnt + BCW'(1);
                        end
                        PARITY: r_perr <= parity_fault(^r_data, w_bit, r_par_type);
                        STOP: begin
                            r_stop_bit <= w_bit;
                            r_decide   <= 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    // Verdict cycle: frame error outranks parity error; a good byte pushes or overruns.
    assign w_pop             = ~w_empty & i_uart_rx_ready;
    assign w_good            = r_decide & r_stop_bit & ~r_perr;
    assign w_push            = w_good & (~w_full | w_pop);
    assign o_uart_frame_err  = r_decide & ~r_stop_bit;
    assign o_uart_parity_err = r_decide & r_stop_bit & r_perr;
    assign o_uart_overrun    = w_good & w_full & ~w_pop;
    assign o_uart_rx_valid   = ~w_empty;
    assign o_uart_fifo_full  = w_full;
    assign o_uart_rx_busy    = (r_state != IDLE);

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_WIDTH)
    ) u_fifo (
        .i_clk   (i_uart_clk),
        .i_rst   (i_uart_rst),
        .i_push  (w_push),
        .i_wdata (r_data),
        .i_pop   (w_pop),
        .o_rdata (o_uart_rx_pdata),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

endmodule

// File: tb/tb_uart_rx_peripheral.sv
// Directed bench for uart_rx_peripheral (FIFO_DEPTH=4). Serial frames are driven on
// negedges; DUT outputs are sampled on negedges. Build with UART_RX_MAJORITY_EN to add
// the mid-bit glitch case.
module tb_uart_rx_peripheral;

    localparam int DEPTH = 4;
    localparam int DW    = 8;
    localparam int DIVW  = 20;

    logic            clk = 1'b0;
    logic            rst;
    logic [DIVW-1:0] div_in;
    logic            par_en;
    logic            par_type;
    logic            sdata;
    logic            ready;
    logic [DW-1:0]   pdata;
    logic            valid;
    logic            full;
    logic            busy;
    logic            perr;
    logic            ferr;
    logic            ovr;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int perr_n   = 0;
    int ferr_n   = 0;
    int ovr_n    = 0;
    int rise_cyc = 0;
    int start_cyc;
    int bit_len;
    int p0, f0, o0;
    logic valid_q = 1'b0;

    uart_rx_peripheral #(
        .FIFO_DEPTH (DEPTH),
        .DATA_WIDTH (DW),
        .DIV_WIDTH  (DIVW)
    ) dut (
        .i_uart_clk          (clk),
        .i_uart_rst          (rst),
        .i_uart_baud_divisor (div_in),
        .i_uart_parity_en    (par_en),
        .i_uart_parity_type  (par_type),
        .i_uart_rx_sdata     (sdata),
        .i_uart_rx_ready     (ready),
        .o_uart_rx_pdata     (pdata),
        .o_uart_rx_valid     (valid),
        .o_uart_fifo_full    (full),
        .o_uart_rx_busy      (busy),
        .o_uart_parity_err   (perr),
        .o_uart_frame_err    (ferr),
        .o_uart_overrun      (ovr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (perr) perr_n++;
        if (ferr) ferr_n++;
        if (ovr)  ovr_n++;
        if (valid && !valid_q) rise_cyc = cyc;
        valid_q = valid;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        p0 = perr_n;
        f0 = ferr_n;
        o0 = ovr_n;
    endtask

    // One bit period; optionally inverts the line for the single cycle captured at edge glitch_at.
    task automatic bit_out(input logic v, input int glitch_at);
        for (int i = 0; i < bit_len; i++) begin
            sdata = (i == glitch_at) ? ~v : v;
            @(negedge clk);
        end
        sdata = v;
    endtask

    // Full frame followed by one idle bit period. gbit selects a data bit to glitch mid-bit (-1: none).
    task automatic send(input logic [7:0] d, input logic pen, input logic pbit,
                        input logic stop, input int gbit);
        start_cyc = cyc;
        bit_out(1'b0, -1);
        for (int i = 0; i < 8; i++) bit_out(d[i], (i == gbit) ? bit_len / 2 : -1);
        if (pen) bit_out(pbit, -1);
        bit_out(stop, -1);
        sdata = 1'b1;
        repeat (bit_len) @(negedge clk);
    endtask

    task automatic pop_check(input string tag, input logic [7:0] exp);
        check({tag, "_valid"}, 32'(valid), 32'd1);
        check({tag, "_pdata"}, 32'(pdata), 32'(exp));
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        sdata    = 1'b1;
        ready    = 1'b0;
        div_in   = 20'd16;
        par_en   = 1'b0;
        par_type = 1'b0;
        bit_len  = 16;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_pdata", 32'(pdata), 32'd0);
        check("rst_full",  32'(full),  32'd0);
        check("rst_busy",  32'(busy),  32'd0);
        check("rst_pulses", 32'({perr, ferr, ovr}), 32'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // T1: 8N1, 0xA5, latency bound from the start edge
        snap();
        send(8'hA5, 1'b0, 1'b0, 1'b1, -1);
        check("t1_latency_ok", 32'((rise_cyc > start_cyc) && (rise_cyc - start_cyc <= 166)), 32'd1);
        check("t1_errs", 32'((perr_n - p0) + (ferr_n - f0) + (ovr_n - o0)), 32'd0);
        pop_check("t1", 8'hA5);
        check("t1_empty", 32'(valid), 32'd0);

        // T2: even parity; 0x3C has four ones so the correct parity bit is 0
        par_en = 1'b1;
        snap();
        send(8'h3C, 1'b1, 1'b1, 1'b1, -1);
        check("t2_perr", 32'(perr_n - p0), 32'd1);
        check("t2_no_push", 32'(valid), 32'd0);
        check("t2_ferr", 32'(ferr_n - f0), 32'd0);
        send(8'h3C, 1'b1, 1'b0, 1'b1, -1);
        check("t2_perr_once", 32'(perr_n - p0), 32'd1);
        pop_check("t2", 8'h3C);

        // Odd parity: 0x07 has three ones so the correct parity bit is 0; a 1 must fail
        par_type = 1'b1;
        snap();
        send(8'h07, 1'b1, 1'b0, 1'b1, -1);
        check("odd_no_perr", 32'(perr_n - p0), 32'd0);
        pop_check("odd", 8'h07);
        send(8'h07, 1'b1, 1'b1, 1'b1, -1);
        check("odd_perr", 32'(perr_n - p0), 32'd1);
        check("odd_no_push", 32'(valid), 32'd0);
        par_en   = 1'b0;
        par_type = 1'b0;

        // T3: stop bit 0 -> frame error, then a clean 0x12
        snap();
        send(8'h55, 1'b0, 1'b0, 1'b0, -1);
        check("t3_ferr", 32'(ferr_n - f0), 32'd1);
        check("t3_no_push", 32'(valid), 32'd0);
        send(8'h12, 1'b0, 1'b0, 1'b1, -1);
        check("t3_ferr_once", 32'(ferr_n - f0), 32'd1);
        pop_check("t3", 8'h12);

        // T4: one-cycle low glitch on the idle line
        snap();
        sdata = 1'b0;
        @(negedge clk);
        sdata = 1'b1;
        repeat (3) @(negedge clk);
        check("t4_busy_start", 32'(busy), 32'd1);
        repeat (20) @(negedge clk);
        check("t4_idle", 32'(busy), 32'd0);
        check("t4_no_push", 32'(valid), 32'd0);
        check("t4_errs", 32'((perr_n - p0) + (ferr_n - f0) + (ovr_n - o0)), 32'd0);

        // Divisor below the minimum is clamped to 4 clocks per bit
        div_in  = 20'd2;
        bit_len = 4;
        send(8'h9C, 1'b0, 1'b0, 1'b1, -1);
        pop_check("min_div", 8'h9C);
        div_in  = 20'd16;
        bit_len = 16;

        // T5: fill the 4-entry FIFO, overrun on the fifth byte, drain in order
        snap();
        for (int i = 1; i <= 4; i++) send(8'(i), 1'b0, 1'b0, 1'b1, -1);
        check("t5_full", 32'(full), 32'd1);
        check("t5_no_ovr", 32'(ovr_n - o0), 32'd0);
        send(8'h05, 1'b0, 1'b0, 1'b1, -1);
        check("t5_ovr", 32'(ovr_n - o0), 32'd1);
        for (int i = 1; i <= 4; i++) pop_check("t5_pop", 8'(i));
        check("t5_empty", 32'(valid), 32'd0);
        check("t5_not_full", 32'(full), 32'd0);
        check("t5_pdata_zero", 32'(pdata), 32'd0);

        // T6: reset mid-DATA of 0xFF with a byte already queued, then 0x81
        send(8'h5A, 1'b0, 1'b0, 1'b1, -1);
        check("t6_queued", 32'(valid), 32'd1);
        snap();
        bit_out(1'b0, -1);
        bit_out(1'b1, -1);
        bit_out(1'b1, -1);
        bit_out(1'b1, -1);
        check("t6_busy_pre", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_valid", 32'(valid), 32'd0);
        rst = 1'b0;
        repeat (6 * bit_len) @(negedge clk);
        check("t6_errs", 32'((perr_n - p0) + (ferr_n - f0) + (ovr_n - o0)), 32'd0);
        check("t6_still_empty", 32'(valid), 32'd0);
        send(8'h81, 1'b0, 1'b0, 1'b1, -1);
        pop_check("t6", 8'h81);

`ifdef UART_RX_MAJORITY_EN
        // Majority vote hides a one-cycle glitch at the middle of data bit 0
        send(8'hA5, 1'b0, 1'b0, 1'b1, 0);
        pop_check("maj", 8'hA5);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
